alu_seq_core: RTL
=================

Name: alu_seq_core

Overview:
- Parametrised, registered successor to the board-level 4-bit combinational ALU.
- Accepts operand/opcode transactions over a valid/ready handshake.
- Executes single-cycle arithmetic and logic ops, plus a multi-cycle shift-add multiply.
- Returns a double-width result with status flags, and can chain operations by feeding the previous result back as operand A.
- Sits between the switch/key input logic and the LED/7-seg display logic.

Parameters:
- WIDTH, 4, operand width in bits (≥2); result is 2*WIDTH bits.
- CNTW, 4, multiply step counter width; must satisfy 2**CNTW > WIDTH.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand transaction present
- in_ready  out  1  core can accept a transaction
- a  in  WIDTH  operand A (unsigned; signed view used for ovf)
- b  in  WIDTH  operand B
- op  in  3  opcode
- acc_en  in  1  replace A with previous result low WIDTH bits
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- y  out  2*WIDTH  result
- zero  out  1  y == 0
- carry  out  1  carry/borrow/high-half-nonzero
- ovf  out  1  signed overflow
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; y=0; zero=0, carry=0, ovf=0; out_valid=0; prev=0; counter=0.
  - in_ready=1 once rst_n=1.
- State machine: IDLE, MUL, DONE. in_ready=1 only in IDLE. busy=1 in MUL and DONE.
- Accept = in_valid & in_ready. On accept, latch opA, opB and op:
  - opA = acc_en ? prev[WIDTH-1:0] : a; opB = b.
- IDLE→DONE on accept of any non-MUL op. Result and flags are registered at that edge: latency 1 clock, out_valid high the cycle after accept.
- IDLE→MUL on accept of op=101. Multiply is unsigned shift-add, one bit of B per cycle, exactly WIDTH cycles in MUL, then →DONE. out_valid rises WIDTH+1 clocks after accept.
- DONE: out_valid=1; y and flags held stable while out_ready=0. DONE→IDLE on out_ready=1, and prev<=y on that edge. in_valid is ignored in DONE; a new accept is possible the cycle after the result handshake. Peak throughput is 1 result per 2 clocks for non-MUL ops.
- Opcodes (y zero-extended to 2*WIDTH unless stated):
  - 000 ADD: y = opA+opB, WIDTH+1 bits. carry = bit WIDTH. ovf = both signs equal and sum sign differs.
  - 001 SUB: y = (opA-opB) mod 2^WIDTH. carry = borrow (opA<opB unsigned). ovf = operand signs differ and result sign ≠ opA sign.
  - 010 AND, 011 OR, 100 XOR: bitwise; carry=0, ovf=0.
  - 101 MUL: y = full 2*WIDTH product; carry = |y[2W-1:W]; ovf=0.
  - 110 SHL: y = opA << opB[CNTW-1:0], full 2*WIDTH kept, bits beyond 2*WIDTH dropped; carry = |y[2W-1:W]; ovf=0.
  - 111 reserved: y=0, carry=0, ovf=0.
- zero = (y==0) for every op, registered with y.
- Inputs a, b, op and acc_en are sampled only at accept. Changes while busy have no effect.
- Async reset mid-MUL or in DONE: operation aborted, no out_valid pulse, prev cleared.
- out_ready while out_valid=0 is ignored.

Test Plan:
1. WIDTH=4, ADD a=9, b=8 → next cycle y=0x11, carry=1, ovf=1, zero=0; out_ready=1 → in_ready=1 following cycle.
2. SUB a=3, b=5 → y=0x0E, carry=1, ovf=0. SUB a=5, b=5 → y=0, zero=1, carry=0.
3. MUL a=15, b=15 → busy for 4 MUL cycles, out_valid 5 clocks after accept, y=0xE1, carry=1. MUL a=0, b=13 → y=0, zero=1.
4. Backpressure: XOR a=0xA, b=0x6, hold out_ready=0 for 3 cycles while toggling a/b/in_valid → y stays 0x0C, in_ready stays 0, no second accept.
5. Chaining: ADD 2+3 (y=5, consumed), then acc_en=1, a=0xF, b=4, op=ADD → y=9 (uses prev=5, ignores a). After reset, acc_en=1 ADD b=7 → y=7.
6. Reset mid-MUL: pull rst_n low 2 cycles into MUL → y=0, out_valid=0, busy=0 immediately (async). After release, in_ready=1 and a new ADD 1+1 gives y=2.

Source files
------------

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - registered handshake ALU with shift-add multiply and result chaining
module alu_seq_core #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           op,
    input  logic                 acc_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 zero,
    output logic                 carry,
    output logic                 ovf,
    output logic                 busy
);

    localparam int W2 = 2 * WIDTH;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [W2-1:0]     y_q;
    logic              zero_q;
    logic              carry_q;
    logic              ovf_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  prev_q;
    logic [W2-1:0]     prod_q;
    logic [W2-1:0]     mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [CNTW-1:0]   cnt_q;

    logic [WIDTH-1:0]  opa_d;
    logic [WIDTH:0]    sum_d;
    logic [WIDTH-1:0]  diff_d;
    logic [CNTW-1:0]   shamt_d;
    logic [W2-1:0]     shl_d;
    logic [W2-1:0]     alu_y_d;
    logic              alu_c_d;
    logic              alu_v_d;
    logic [W2-1:0]     mul_sum_d;
    logic              accept_d;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;

    // Single-cycle datapath: operand select (chaining) and all one-clock opcodes
    always_comb begin
        accept_d  = in_valid & (state_q == S_IDLE);
        opa_d     = acc_en ? prev_q : a;
        sum_d     = {1'b0, opa_d} + {1'b0, b};
        diff_d    = opa_d - b;
        shamt_d   = CNTW'(b);
        shl_d     = {{WIDTH{1'b0}}, opa_d} << shamt_d;
        mul_sum_d = prod_q + (mplier_q[0] ? mcand_q : '0);
        alu_y_d   = '0;
        alu_c_d   = 1'b0;
        alu_v_d   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_y_d = {{(WIDTH-1){1'b0}}, sum_d};
                alu_c_d = sum_d[WIDTH];
                alu_v_d = (opa_d[WIDTH-1] == b[WIDTH-1]) && (sum_d[WIDTH-1] != opa_d[WIDTH-1]);
            end
            OP_SUB: begin
                alu_y_d = {{WIDTH{1'b0}}, diff_d};
                alu_c_d = (opa_d < b);
                alu_v_d = (opa_d[WIDTH-1] != b[WIDTH-1]) && (diff_d[WIDTH-1] != opa_d[WIDTH-1]);
            end
            OP_AND: alu_y_d = {{WIDTH{1'b0}}, opa_d & b};
            OP_OR:  alu_y_d = {{WIDTH{1'b0}}, opa_d | b};
            OP_XOR: alu_y_d = {{WIDTH{1'b0}}, opa_d ^ b};
            OP_SHL: begin
                alu_y_d = shl_d;
                alu_c_d = |shl_d[W2-1:WIDTH];
            end
            default: begin
                // MUL is handled by the sequencer; the reserved opcode yields zero
                alu_y_d = '0;
            end
        endcase
    end

    // Control FSM with registered result, flags and chaining register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            y_q         <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            prev_q      <= '0;
            prod_q      <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        if (op == OP_MUL) begin
                            prod_q   <= '0;
                            mcand_q  <= {{WIDTH{1'b0}}, opa_d};
                            mplier_q <= b;
                            cnt_q    <= '0;
                            state_q  <= S_MUL;
                        end else begin
                            y_q         <= alu_y_d;
                            zero_q      <= (alu_y_d == '0);
                            carry_q     <= alu_c_d;
                            ovf_q       <= alu_v_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    // One multiplier bit per clock, LSB first
                    prod_q   <= mul_sum_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNTW'(WIDTH - 1)) begin
                        y_q         <= mul_sum_d;
                        zero_q      <= (mul_sum_d == '0);
                        carry_q     <= |mul_sum_d[W2-1:WIDTH];
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        prev_q      <= y_q[WIDTH-1:0];
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
